// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - two-master data-memory bus plus RAM data port
interface dmem_arbiter_if;
  logic        m0_req_i;
  logic        m0_we_i;
  logic [31:0] m0_addr_i;
  logic [31:0] m0_data_i;
  logic        m0_ack_o;
  logic [31:0] m0_data_o;
  logic        m1_req_i;
  logic        m1_we_i;
  logic        m1_lock_i;
  logic [31:0] m1_addr_i;
  logic [31:0] m1_data_i;
  logic        m1_ack_o;
  logic [31:0] m1_data_o;
  logic        ram_ce_o;
  logic        ram_we_o;
  logic [31:0] ram_addr_o;
  logic [31:0] ram_data_o;
  logic [31:0] ram_data_i;

  modport slave (
    input  m0_req_i, m0_we_i, m0_addr_i, m0_data_i,
    output m0_ack_o, m0_data_o,
    input  m1_req_i, m1_we_i, m1_lock_i, m1_addr_i, m1_data_i,
    output m1_ack_o, m1_data_o,
    output ram_ce_o, ram_we_o, ram_addr_o, ram_data_o,
    input  ram_data_i
  );

  modport master (
    output m0_req_i, m0_we_i, m0_addr_i, m0_data_i,
    input  m0_ack_o, m0_data_o,
    output m1_req_i, m1_we_i, m1_lock_i, m1_addr_i, m1_data_i,
    input  m1_ack_o, m1_data_o,
    input  ram_ce_o, ram_we_o, ram_addr_o, ram_data_o,
    output ram_data_i
  );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin arbiter of CPU (M0) and DMA (M1) onto one RAM port
// M1 may hold the port for up to LOCK_MAX locked beats; M0 always gets a bubble after.
module dmem_arbiter #(
  parameter int LOCK_MAX = 16
) (
  input  logic           clk_i,
  input  logic           rst_i,
  dmem_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  localparam logic [7:0] LOCK_LAST = 8'(LOCK_MAX - 1);

  state_t     state;
  state_t     state_nx;
  logic       last_grant;
  logic [7:0] beat_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      beat_cnt   <= 8'd0;
    end else begin
      state <= state_nx;
      if (state_nx == GNT0) begin
        last_grant <= 1'b0;
      end else if (state_nx == GNT1) begin
        last_grant <= 1'b1;
      end
      if (state == GNT1 && state_nx == GNT1) begin
        beat_cnt <= (beat_cnt == 8'hFF) ? beat_cnt : beat_cnt + 8'd1;
      end else begin
        beat_cnt <= 8'd0;
      end
    end
  end

  always_comb begin
    state_nx       = state;
    bus.m0_ack_o   = 1'b0;
    bus.m0_data_o  = 32'd0;
    bus.m1_ack_o   = 1'b0;
    bus.m1_data_o  = 32'd0;
    bus.ram_ce_o   = 1'b0;
    bus.ram_we_o   = 1'b0;
    bus.ram_addr_o = 32'd0;
    bus.ram_data_o = 32'd0;

    case (state)
      IDLE: begin
        if (bus.m0_req_i && bus.m1_req_i) begin
          state_nx = last_grant ? GNT0 : GNT1;
        end else if (bus.m0_req_i) begin
          state_nx = GNT0;
        end else if (bus.m1_req_i) begin
          state_nx = GNT1;
        end else begin
          state_nx = IDLE;
        end
      end
      GNT0: state_nx = IDLE;
      GNT1: begin
        if (bus.m1_lock_i && bus.m1_req_i && beat_cnt < LOCK_LAST) begin
          state_nx = GNT1;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase

    // Reset gates every output in the same cycle so a GNT cycle cannot write.
    if (!rst_i) begin
      case (state)
        GNT0: begin
          bus.ram_ce_o   = 1'b1;
          bus.ram_we_o   = bus.m0_we_i;
          bus.ram_addr_o = bus.m0_addr_i;
          bus.ram_data_o = bus.m0_data_i;
          bus.m0_ack_o   = 1'b1;
          bus.m0_data_o  = bus.ram_data_i;
        end
        GNT1: begin
          bus.ram_ce_o   = 1'b1;
          bus.ram_we_o   = bus.m1_we_i;
          bus.ram_addr_o = bus.m1_addr_i;
          bus.ram_data_o = bus.m1_data_i;
          bus.m1_ack_o   = 1'b1;
          bus.m1_data_o  = bus.ram_data_i;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(bus.m0_ack_o && bus.m1_ack_o));
      assert (state != IDLE || !bus.ram_ce_o);
      assert (beat_cnt <= LOCK_LAST);
    end
  end
endmodule
